dmi_host_bridge: RTL

Memory-mapped DMI initiator: a register-programmed bridge that lets a bus host (boot ROM, test controller or secure core) issue Debug Module Interface reads and writes to a `dm_top` instance without a JTAG DTM. It drives the DM's DMI request/response channels and `dmi_rst_ni` from a single clock domain. It exposes a small register file on the same `slave_*` bus flavour used by the debug module, with a one-transaction-at-a-time FSM, timeout and abort.

---
 rtl/dmi_host_bridge.sv | 109 ++++++++++
 1 files changed

// File: rtl/dmi_host_bridge.sv
// dmi_host_bridge: register-programmed DMI initiator driving a dm_top request/response channel
// from a small slave-bus register file, one transaction at a time, with timeout and abort.
package dm;
  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;
  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;
endpackage

module dmi_host_bridge #(
  parameter int unsigned BusWidth      = 32,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  slave_req_i,
  input  logic                  slave_we_i,
  input  logic [BusWidth-1:0]   slave_addr_i,
  input  logic [BusWidth/8-1:0] slave_be_i,
  input  logic [BusWidth-1:0]   slave_wdata_i,
  output logic [BusWidth-1:0]   slave_rdata_o,
  output logic                  slave_err_o,
  output logic                  dmi_rst_no,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output dm::dmi_req_t          dmi_req_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  dm::dmi_resp_t         dmi_resp_i,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e state, state_d;
  logic [6:0] addr_q;
  logic [31:0] wdata_q, rdata_q, cnt;
  logic [1:0] resp_q;
  logic timeout_q, overrun_q;
  dm::dmi_req_t req_q;
  logic [BusWidth-1:0] rmux;
  logic [2:0] idx;
  logic wr, busy, cmd_wr, start, overrun_set, ctrl_wr, tmo, abort, kill, complete, status_clr;
  logic unused_addr;
  assign idx = slave_addr_i[4:2];
  assign wr = slave_req_i & slave_we_i;
  assign busy = state != IDLE;
  assign cmd_wr = wr && idx == 3'd2 && slave_be_i[0];
  // op 1 (read) and 2 (write) are exactly the encodings whose two bits differ
  assign start = cmd_wr && !busy && ^slave_wdata_i[1:0];
  assign overrun_set = cmd_wr && busy;
  assign ctrl_wr = wr && idx == 3'd5 && slave_wdata_i[0];
  assign tmo = TimeoutCycles != 0 && busy && cnt == 32'(TimeoutCycles - 1);
  assign abort = ctrl_wr && busy;
  assign kill = tmo || abort;
  assign complete = state == RESP && dmi_resp_valid_i && !kill;
  assign status_clr = wr && idx == 3'd3 && slave_be_i[0];
  assign unused_addr = ^{slave_addr_i[BusWidth-1:5], slave_addr_i[1:0]};
  assign busy_o = busy;
  assign dmi_req_valid_o = state == REQ;
  assign dmi_resp_ready_o = state == RESP;
  assign dmi_req_o = req_q;

  always_comb begin
    state_d = kill ? IDLE : start ? REQ : (state == REQ && dmi_req_ready_i) ? RESP : complete ? IDLE : state;
    rmux = idx == 3'd0 ? BusWidth'(addr_q) :
           idx == 3'd1 ? BusWidth'(wdata_q) :
           idx == 3'd3 ? BusWidth'({overrun_q, timeout_q, resp_q, busy}) :
           idx == 3'd4 ? BusWidth'(rdata_q) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
      resp_q <= '0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      req_q <= '0;
      slave_rdata_o <= '0;
      slave_err_o <= 1'b0;
      done_o <= 1'b0;
      dmi_rst_no <= 1'b1;
    end else begin
      state <= state_d;
      cnt <= start ? '0 : busy ? cnt + 32'd1 : cnt;
      if (wr && idx == 3'd0 && slave_be_i[0]) addr_q <= slave_wdata_i[6:0];
      for (int b = 0; b < 4; b++)
        if (wr && idx == 3'd1 && slave_be_i[b]) wdata_q[8*b +: 8] <= slave_wdata_i[8*b +: 8];
      if (start) req_q <= '{addr: addr_q, op: slave_wdata_i[1:0], data: wdata_q};
      resp_q <= kill ? 2'd3 : complete ? dmi_resp_i.resp : resp_q;
      if (complete && req_q.op == 2'd1) rdata_q <= dmi_resp_i.data;
      // a new event in the same cycle as its W1C clear leaves the flag set
      timeout_q <= tmo | (timeout_q & ~(status_clr & slave_wdata_i[3]));
      overrun_q <= overrun_set | (overrun_q & ~(status_clr & slave_wdata_i[4]));
      slave_err_o <= slave_req_i && (idx[2:1] == 2'b11 || overrun_set);
      slave_rdata_o <= (slave_req_i && !slave_we_i) ? rmux : '0;
      done_o <= kill || complete;
      dmi_rst_no <= !(tmo || ctrl_wr);
    end
  end
endmodule
